dmem_wait_state_bridge: RTL
===========================

# dmem_wait_state_bridge

Bridges the processor core's req/ack data-memory port to a single-port synchronous-read SRAM, inserting a fixed number of wait states before each access. It sits directly downstream of `simple_processor`'s `dmem_*` port and replaces the zero-latency `ack = req` tie-off with a realistic, stall-inducing memory. It latches each request, sequences the SRAM strobe and returns a one-cycle `ack_o` with read data. It optionally flags misaligned word accesses without touching memory.

## Interface
- `ADDR_WIDTH`, default 32: address width, matches the core.
- `DATA_WIDTH`, default 32: data width, matches the core.
- `WAIT_CYCLES`, default 2: wait states inserted before the SRAM strobe; 0 is legal.
- `ALIGN_CHECK`, default 1: if 1, requests with `addr_i[1:0] != 0` complete with `err_o` and no SRAM access.
- `clk_i`, input, 1: single clock; all logic is on its rising edge.
- `arst_ni`, input, 1: asynchronous, active-low reset.
- `req_i`, input, 1: core request; held high with stable `we_i`/`addr_i`/`wdata_i` until `ack_o`.
- `we_i`, input, 1: 1 = write, 0 = read.
- `addr_i`, input, ADDR_WIDTH: byte address.
- `wdata_i`, input, DATA_WIDTH: write data.
- `rdata_o`, output, DATA_WIDTH: read data; valid only while `ack_o`=1 and read; 0 otherwise.
- `ack_o`, output, 1: one-cycle completion pulse.
- `err_o`, output, 1: misaligned access; asserted only together with `ack_o`.
- `busy_o`, output, 1: high in any state other than IDLE.
- `mem_en_o`, output, 1: SRAM access strobe, one cycle per access.
- `mem_we_o`, output, 1: SRAM write enable; only with `mem_en_o`.
- `mem_addr_o`, output, ADDR_WIDTH: latched address.
- `mem_wdata_o`, output, DATA_WIDTH: latched write data.
- `mem_rdata_i`, input, DATA_WIDTH: SRAM read data, valid the cycle after the `mem_en_o` cycle.

## Operation
- States are IDLE, WAIT, ACCESS, RESP and ERR.
- IDLE with `req_i`=1: latch `we_i`/`addr_i`/`wdata_i` and load the down-counter with `WAIT_CYCLES`.
  - Misaligned address and `ALIGN_CHECK`=1: go to ERR.
  - Otherwise, `WAIT_CYCLES`=0: go to ACCESS.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter each cycle; go to ACCESS on the cycle the counter reaches 1. The counter is `$clog2(WAIT_CYCLES+1)` bits wide (min 1) and never wraps.
- ACCESS: `mem_en_o`=1 and `mem_we_o`=latched `we`; go to RESP.
- RESP: `ack_o`=1.
  - Read: `rdata_o`=`mem_rdata_i`.
  - Write: `rdata_o`=0.
  - Go to IDLE.
- ERR: `ack_o`=1, `err_o`=1, `rdata_o`=0; go to IDLE. `mem_en_o` is never asserted on this path.
- Requests are evaluated only in IDLE. `req_i` still high in the cycle after `ack_o` is a new request (back-to-back is allowed, with no bubble beyond the IDLE cycle).
- Input changes or `req_i` deassertion mid-transaction are ignored. The latched transaction completes and `ack_o` is still issued.
- `mem_addr_o`/`mem_wdata_o` hold the latched values until the next request is latched.
- Reset (asynchronous, at any time including mid-WAIT/ACCESS): state goes to IDLE and all outputs go to 0. An in-flight transaction is dropped with no `ack_o`, and the core re-issues it after reset.

## Timing
- Request sampled high in IDLE at edge E0.
- Aligned access: `mem_en_o` is high in cycle E0+`WAIT_CYCLES`+1 and `ack_o` is high in cycle E0+`WAIT_CYCLES`+2.
- Misaligned access: `ack_o` is high in cycle E0+1.
- Minimum aligned transaction period: `WAIT_CYCLES`+3 cycles, counting the IDLE cycle.
- `ack_o`, `err_o`, `mem_en_o` and `mem_we_o` decode from registered state only (no combinational path from `req_i`).
- `rdata_o` is a combinational pass-through of `mem_rdata_i`, gated by RESP and read.
- Reset values: all outputs are 0 and the state is IDLE.

## Test plan
- Read, `WAIT_CYCLES`=2: SRAM[0x100]=0xDEADBEEF, read at 0x100 sampled at E0.
  - `mem_en_o` is high only in cycle E0+3.
  - `ack_o` is high only in cycle E0+4 with `rdata_o`=0xDEADBEEF, `err_o`=0.
- Write then read back, `WAIT_CYCLES`=0: write 0x12345678 to 0x200.
  - Write: `mem_en_o`=`mem_we_o`=1 in cycle E0+1 and `ack_o` in cycle E0+2.
  - Back-to-back read of 0x200 returns 0x12345678.
- Misaligned address 0x102, `ALIGN_CHECK`=1: `ack_o`=`err_o`=1 in cycle E0+1, `rdata_o`=0, `mem_en_o` never asserted.
- Protocol abuse: `addr_i` changes from 0x100 to 0x300 and `req_i` drops during WAIT. The access still goes to 0x100 and exactly one `ack_o` is issued.
- Reset mid-WAIT: `arst_ni` pulsed low between edges.
  - All outputs go to 0 immediately.
  - No `ack_o` or `mem_en_o` for the dropped request.
  - A new read after release completes with normal latency.
- Core integration: a 13-instruction program with loads/stores against a `WAIT_CYCLES`=3 bridge. Final GPR and memory state match the reference model exactly.

Source files
------------

// File: rtl/dmem_wait_state_bridge.sv
// Req/ack data-memory port to synchronous-read SRAM bridge with a fixed number of
// wait states ahead of each SRAM strobe and optional misalignment rejection.
module dmem_wait_state_bridge #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_ERR
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic                    misaligned;

    assign misaligned = ALIGN_CHECK && (addr_i[1:0] != 2'b00);

    // Saturating decrement so the counter can never wrap.
    assign cnt_d = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        if (misaligned) begin
                            state_q <= S_ERR;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q  <= S_ACCESS;
                            mem_en_q <= 1'b1;
                            mem_we_q <= we_i;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q <= CNT_ONE) begin
                        state_q  <= S_ACCESS;
                        mem_en_q <= 1'b1;
                        mem_we_q <= we_q;
                    end
                end
                S_ACCESS: begin
                    state_q <= S_RESP;
                    ack_q   <= 1'b1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // SRAM data arrives the cycle after the strobe, which is exactly the RESP cycle.
    assign rdata_o = ((state_q == S_RESP) && !we_q) ? mem_rdata_i : '0;

endmodule
